multi_digit_seven_segment_scanner: RTL and testbench
====================================================

// Module: multi_digit_seven_segment_scanner
// PURPOSE
//  Time-multiplexed driver for an N-digit common-anode 7-segment display (Basys-class boards).
//  Scans one digit per refresh slot from a parametrised prescaler.
//  Adds frame-synchronous (tear-free) update, per-digit dp/blank, leading-zero suppression,
//  PWM brightness and an anode guard interval against ghosting.
//  Sits between user logic (counters, BCD converters) and the board seg/dp/an pins.
// PARAMETERS
//  DIGITS    4       number of digits scanned (1..8)
//  PRESCALE  100000  clk cycles per digit slot (>= GUARD+2)
//  GUARD     4       cycles at start of each slot with all anodes off (0 allowed)
//  BRIGHT_W  4       width of brightness input
// PORTS
//  clk           in   1            system clock, all logic rising-edge
//  reset         in   1            synchronous, active-high
//  digits_in     in   4*DIGITS     hex nibbles, [3:0] = digit 0 (least significant)
//  dp_in         in   DIGITS       1 = light decimal point of digit i
//  blank_in      in   DIGITS       1 = force digit i dark
//  lz_suppress   in   1            1 = blank leading zeros (digit 0 never suppressed)
//  brightness    in   BRIGHT_W     duty level; all-ones = full on
//  load          in   1            capture digits_in/dp_in/blank_in into shadow regs
//  seg           out  7            cathodes a..g, active-low
//  dp            out  1            decimal point, active-low
//  an            out  DIGITS       anodes, active-low, at most one low
//  frame_tick    out  1            1-cycle pulse when last digit slot ends
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. Next edge with reset=1: an=all 1s, seg=7'h7F,
//    dp=1, frame_tick=0, slot counter=0, digit index=0, pwm counter=0, pending=0,
//    shadow+active digits=0, dp=0, blank=all 1s (display dark until first frame transfer).
//  - Reset mid-scan: same values, pending load discarded; scan restarts at digit 0.
//  - Slot counter 0..PRESCALE-1; on PRESCALE-1 wraps to 0 and index advances; index DIGITS-1 -> 0.
//    frame_tick=1 exactly in the cycle after the index-(DIGITS-1)-to-0 wrap edge (registered).
//    DIGITS=1: index fixed 0, frame_tick every PRESCALE cycles.
//  - load=1: shadow <= inputs, pending <= 1. On frame wrap with pending=1: active <= shadow,
//    pending <= 0. load in the wrap cycle: shadow updated, transfer uses pre-edge shadow, pending stays 1.
//    Repeated loads within a frame: last one wins.
//  - Leading-zero mask: digit i (i>0) suppressed when lz_suppress=1 and active nibbles i..DIGITS-1 all 0.
//  - PWM counter (BRIGHT_W bits) free-runs; pwm_on = (pwm_cnt <= brightness).
//  - an[i] low iff i==index && slot_cnt>=GUARD && pwm_on && !blank[i] && !lz_mask[i].
//  - seg = decode(active nibble[index]); dp = ~active_dp[index]; when digit dark seg=7'h7F, dp=1.
//  - All outputs registered: 1-cycle latency from counter state to pins; no combinational in->out path.
//  - brightness, lz_suppress sampled live (not shadowed).
// STRUCTURE
//  - Shared package seven_seg_pkg: SEG_BLANK=7'h7F, NIBBLE_W=4, active-low polarity constants,
//    clog2 helper for index/slot counter widths.
//  - One sub-module: existing HexTo7SegmentDecoder (nibble -> active-low a..g), single instance
//    on the muxed nibble. Counters, shadow/active regs, masks, output regs in this module.
// TESTING  (DIGITS=4, PRESCALE=8, GUARD=1, BRIGHT_W=2, brightness=2'b11 unless noted)
//  1 reset 3 cycles, release, no load -> an=4'hF, seg=7'h7F, dp=1 for all cycles; frame_tick every 32 cycles.
//  2 load digits=16'h1234 dp=4'b0100, wait frame_tick -> per slot an=1110/1101/1011/0111 for 7 of 8
//    cycles (off 1 guard cycle), seg=decode(4,3,2,1), dp=0 only while an=1011.
//  3 load 16'h0070, lz_suppress=1 -> digits 3,2 dark (an bits never low), digits 1,0 show 7,0;
//    lz_suppress=0 -> all four shown incl. leading 0s.
//  4 brightness=2'b00 -> each digit's anode low only in slot cycles where pwm_cnt==0; duty 1/4 of non-guard time.
//  5 load 16'hAAAA mid-frame then 16'hBBBB before wrap -> no change until frame_tick, then all show B;
//    load asserted in wrap cycle -> applied one frame later.
//  6 assert reset at slot 5 of digit 2 -> next cycle outputs at reset values, pending cleared,
//    scan restarts at digit 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display driver.
package seven_seg_pkg;

  localparam int         NIBBLE_W  = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic       AN_ON     = 1'b0;
  localparam logic       AN_OFF    = 1'b1;
  localparam logic       DP_ON     = 1'b0;
  localparam logic       DP_OFF    = 1'b1;

  // Counter width for values 0..value-1, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/multi_digit_seven_segment_scanner_decoder.sv
// Hex nibble to active-low seven-segment pattern, seg_o[0]=a ... seg_o[6]=g.
module HexTo7SegmentDecoder
  import seven_seg_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble_i,
  output logic [6:0]          seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/multi_digit_seven_segment_scanner.sv
// Scans DIGITS common-anode digits one slot at a time, with tear-free frame updates,
// leading-zero suppression, PWM dimming and an all-off guard at the start of each slot.
module multi_digit_seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 100000,
  parameter int GUARD    = 4,
  parameter int BRIGHT_W = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NIBBLE_W*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]            dp_in,
  input  logic [DIGITS-1:0]            blank_in,
  input  logic                         lz_suppress,
  input  logic [BRIGHT_W-1:0]          brightness,
  input  logic                         load,
  output logic [6:0]                   seg,
  output logic                         dp,
  output logic [DIGITS-1:0]            an,
  output logic                         frame_tick
);

  localparam int                IDX_W      = clog2_min1(DIGITS);
  localparam int                SLOT_W     = clog2_min1(PRESCALE);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(PRESCALE - 1);
  localparam logic [SLOT_W-1:0] SLOT_GUARD = SLOT_W'(GUARD);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);

  logic [SLOT_W-1:0]          slot_q, slot_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [BRIGHT_W-1:0]        pwm_q;
  logic                       pending_q;
  logic [NIBBLE_W*DIGITS-1:0] shadow_digits_q, active_digits_q;
  logic [DIGITS-1:0]          shadow_dp_q, active_dp_q;
  logic [DIGITS-1:0]          shadow_blank_q, active_blank_q;
  logic [6:0]                 seg_q, seg_d;
  logic                       dp_q, dp_d;
  logic [DIGITS-1:0]          an_q, an_d;
  logic                       tick_q;

  logic                       slot_wrap, frame_wrap, lit;
  logic [DIGITS-1:0]          lz_mask;
  logic [NIBBLE_W-1:0]        nibble [DIGITS];
  logic [6:0]                 dec_seg;

  assign slot_wrap  = (slot_q == SLOT_LAST);
  assign frame_wrap = slot_wrap && (idx_q == IDX_LAST);
  assign slot_d     = slot_wrap ? '0 : slot_q + 1'b1;
  assign idx_d      = !slot_wrap ? idx_q : (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    logic nz_above;
    nz_above = 1'b0;
    lz_mask  = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      nz_above   = nz_above | (|active_digits_q[i*NIBBLE_W +: NIBBLE_W]);
      lz_mask[i] = lz_suppress & ~nz_above;
    end
  end

  assign lit = (slot_q >= SLOT_GUARD) && (pwm_q <= brightness)
            && !active_blank_q[idx_q] && !lz_mask[idx_q];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nibble[gi] = active_digits_q[gi*NIBBLE_W +: NIBBLE_W];
      assign an_d[gi]   = (lit && idx_q == IDX_W'(gi)) ? AN_ON : AN_OFF;
    end
  endgenerate

  HexTo7SegmentDecoder u_decoder (
    .nibble_i (nibble[idx_q]),
    .seg_o    (dec_seg)
  );

  assign seg_d = lit ? dec_seg : SEG_BLANK;
  assign dp_d  = lit ? ~active_dp_q[idx_q] : DP_OFF;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q          <= '0;
      idx_q           <= '0;
      pwm_q           <= '0;
      pending_q       <= 1'b0;
      shadow_digits_q <= '0;
      active_digits_q <= '0;
      shadow_dp_q     <= '0;
      active_dp_q     <= '0;
      shadow_blank_q  <= '1;
      active_blank_q  <= '1;
      seg_q           <= SEG_BLANK;
      dp_q            <= DP_OFF;
      an_q            <= {DIGITS{AN_OFF}};
      tick_q          <= 1'b0;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
      pwm_q  <= pwm_q + 1'b1;
      if (load) begin
        shadow_digits_q <= digits_in;
        shadow_dp_q     <= dp_in;
        shadow_blank_q  <= blank_in;
      end
      // Transfer takes the pre-edge shadow; a load in the same cycle waits a frame.
      if (frame_wrap && pending_q) begin
        active_digits_q <= shadow_digits_q;
        active_dp_q     <= shadow_dp_q;
        active_blank_q  <= shadow_blank_q;
      end
      pending_q <= load | (pending_q & ~frame_wrap);
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      tick_q    <= frame_wrap;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_multi_digit_seven_segment_scanner.sv
// Bench for the seven-segment scanner: cycle-count reference model, vector table and corner sequences.
module tb_multi_digit_seven_segment_scanner;

  localparam int D     = 4;
  localparam int P     = 8;
  localparam int G     = 1;
  localparam int BW    = 2;
  localparam int FRAME = D * P;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, blank_in;
  logic        lz_suppress;
  logic [1:0]  brightness;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  always #5 clk = ~clk;

  multi_digit_seven_segment_scanner #(
    .DIGITS(D), .PRESCALE(P), .GUARD(G), .BRIGHT_W(BW)
  ) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
    .lz_suppress(lz_suppress), .brightness(brightness), .load(load),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counters derived from cycles since reset, plus shadow/active frame copies.
  int          m_cyc;
  logic [15:0] m_sh_dig, m_ac_dig;
  logic [3:0]  m_sh_dp, m_ac_dp, m_sh_bl, m_ac_bl;
  bit          m_pend;
  logic [6:0]  e_seg;
  logic        e_dp, e_tick;
  logic [3:0]  e_an;

  int          lit_cnt [D];
  logic [6:0]  seen_seg [D];
  logic [3:0]  seen_dp;
  int          seg_bad, multi_low;

  typedef struct packed {
    logic [15:0]     dig;
    logic [3:0]      dpv;
    logic [3:0]      blank;
    logic            lz;
    logic [1:0]      br;
    logic [3:0][3:0] exp_lit;
    logic [3:0]      exp_dp;
  } vec_t;
  vec_t vecs [8];

  // Lit segments listed active-high as {g,f,e,d,c,b,a}; the pins are the complement.
  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] on;
    case (v)
      4'h0: on = 7'h3F; 4'h1: on = 7'h06; 4'h2: on = 7'h5B; 4'h3: on = 7'h4F;
      4'h4: on = 7'h66; 4'h5: on = 7'h6D; 4'h6: on = 7'h7D; 4'h7: on = 7'h07;
      4'h8: on = 7'h7F; 4'h9: on = 7'h6F; 4'hA: on = 7'h77; 4'hB: on = 7'h7C;
      4'hC: on = 7'h39; 4'hD: on = 7'h5E; 4'hE: on = 7'h79; default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    int slot, idx, pwm;
    bit lit, nz;
    logic [3:0] lzm;
    if (reset) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
      m_cyc = 0; m_pend = 0;
      m_sh_dig = '0; m_ac_dig = '0; m_sh_dp = '0; m_ac_dp = '0;
      m_sh_bl = 4'hF; m_ac_bl = 4'hF;
    end else begin
      slot = m_cyc % P;
      idx  = (m_cyc / P) % D;
      pwm  = m_cyc % (1 << BW);
      lzm = '0;
      nz  = 0;
      for (int i = D - 1; i >= 1; i--) begin
        nz = nz | (m_ac_dig[4*i +: 4] != 4'h0);
        lzm[i] = lz_suppress && !nz;
      end
      lit = (slot >= G) && (pwm <= int'(brightness)) && !m_ac_bl[idx] && !lzm[idx];
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      if (lit) begin
        e_an[idx] = 1'b0;
        e_seg     = seg_of(m_ac_dig[4*idx +: 4]);
        e_dp      = !m_ac_dp[idx];
      end
      e_tick = ((m_cyc % FRAME) == FRAME - 1);
      if (e_tick && m_pend) begin
        m_ac_dig = m_sh_dig; m_ac_dp = m_sh_dp; m_ac_bl = m_sh_bl; m_pend = 0;
      end
      if (load) begin
        m_sh_dig = digits_in; m_sh_dp = dp_in; m_sh_bl = blank_in; m_pend = 1;
      end
      m_cyc++;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (an !== e_an || seg !== e_seg || dp !== e_dp || frame_tick !== e_tick) begin
      n_fail++;
      $display("FAIL pins cyc=%0d an=%b/%b seg=%h/%h dp=%b/%b tick=%b/%b (got/expected)",
               m_cyc, an, e_an, seg, e_seg, dp, e_dp, frame_tick, e_tick);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    digits_in = d; dp_in = p; blank_in = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    int n;
    bit got;
    n = 0; got = 0;
    while (!got && n < 2 * FRAME + 2) begin
      step();
      n++;
      got = (frame_tick === 1'b1);
    end
    check_int({tag, "_tick_seen"}, int'(got), 1);
  endtask

  task automatic run_frame();
    for (int i = 0; i < D; i++) begin
      lit_cnt[i] = 0; seen_seg[i] = 7'h7F;
    end
    seen_dp = '0; seg_bad = 0; multi_low = 0;
    repeat (FRAME) begin
      step();
      if ($countones(~an) > 1) multi_low++;
      for (int i = 0; i < D; i++) begin
        if (an[i] === 1'b0) begin
          lit_cnt[i]++;
          if (lit_cnt[i] == 1) seen_seg[i] = seg;
          else if (seg !== seen_seg[i]) seg_bad++;
          if (dp === 1'b0) seen_dp[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_frame_shows(input string tag, input logic [3:0] v);
    run_frame();
    for (int i = 0; i < D; i++) begin
      check_int($sformatf("%s_lit%0d", tag, i), lit_cnt[i], P - G);
      check_int($sformatf("%s_seg%0d", tag, i), int'(seen_seg[i]), int'(seg_of(v)));
    end
  endtask

  task automatic dark_frames(input string tag);
    int bright_obs, t1, t2;
    bright_obs = 0; t1 = -1; t2 = -1;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      step();
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) bright_obs++;
      if (frame_tick === 1'b1) begin
        if (t1 < 0) t1 = k;
        else if (t2 < 0) t2 = k;
      end
    end
    check_int({tag, "_dark"}, bright_obs, 0);
    check_int({tag, "_tick1"}, t1, FRAME);
    check_int({tag, "_tick2"}, t2, 2 * FRAME);
    $display("%s: dark observations with output active=%0d, ticks at %0d and %0d", tag, bright_obs, t1, t2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fails_before, n, early;
    bit got;

    vecs[0] = '{dig:16'h1234, dpv:4'b0100, blank:4'b0000, lz:1'b0, br:2'b11,
                exp_lit:{4'd7, 4'd7, 4'd7, 4'd7}, exp_dp:4'b0100};
    vecs[1] = '{dig:16'h0070, dpv:4'b0000, blank:4'b0000, lz:1'b1, br:2'b11,
                exp_lit:{4'd0, 4'd0, 4'd7, 4'd7}, exp_dp:4'b0000};
    vecs[2] = '{dig:16'h0070, dpv:4'b0000, blank:4'b0000, lz:1'b0, br:2'b11,
                exp_lit:{4'd7, 4'd7, 4'd7, 4'd7}, exp_dp:4'b0000};
    vecs[3] = '{dig:16'h0070, dpv:4'b0000, blank:4'b0000, lz:1'b1, br:2'b00,
                exp_lit:{4'd0, 4'd0, 4'd1, 4'd1}, exp_dp:4'b0000};
    vecs[4] = '{dig:16'hABCD, dpv:4'b1001, blank:4'b0010, lz:1'b0, br:2'b01,
                exp_lit:{4'd3, 4'd3, 4'd0, 4'd3}, exp_dp:4'b1001};
    vecs[5] = '{dig:16'h8E0F, dpv:4'b1111, blank:4'b0000, lz:1'b1, br:2'b10,
                exp_lit:{4'd5, 4'd5, 4'd5, 4'd5}, exp_dp:4'b1111};
    vecs[6] = '{dig:16'h0005, dpv:4'b0001, blank:4'b0000, lz:1'b1, br:2'b11,
                exp_lit:{4'd0, 4'd0, 4'd0, 4'd7}, exp_dp:4'b0001};
    vecs[7] = '{dig:16'h0000, dpv:4'b0010, blank:4'b0000, lz:1'b1, br:2'b11,
                exp_lit:{4'd0, 4'd0, 4'd0, 4'd7}, exp_dp:4'b0000};

    reset = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; blank_in = '0;
    lz_suppress = 1'b0; brightness = 2'b11;

    // Reset held three cycles, then an idle display with no load.
    repeat (3) step();
    reset = 1'b0;
    dark_frames("reset_idle");

    // Table of display contents, each checked over one whole frame after transfer.
    for (int v = 0; v < 8; v++) begin
      fails_before = n_fail;
      brightness  = vecs[v].br;
      lz_suppress = vecs[v].lz;
      do_load(vecs[v].dig, vecs[v].dpv, vecs[v].blank);
      wait_tick($sformatf("vec%0d", v));
      run_frame();
      for (int i = 0; i < D; i++) begin
        check_int($sformatf("vec%0d_lit%0d", v, i), lit_cnt[i], int'(vecs[v].exp_lit[i]));
        if (vecs[v].exp_lit[i] != 4'd0)
          check_int($sformatf("vec%0d_seg%0d", v, i), int'(seen_seg[i]), int'(seg_of(vecs[v].dig[4*i +: 4])));
      end
      check_int($sformatf("vec%0d_dp", v), int'(seen_dp), int'(vecs[v].exp_dp));
      check_int($sformatf("vec%0d_seg_stable", v), seg_bad, 0);
      check_int($sformatf("vec%0d_one_anode", v), multi_low, 0);
      $display("vec %0d: digits=%h dp=%b blank=%b lz=%b bright=%0d lit=%0d/%0d/%0d/%0d new_fails=%0d",
               v, vecs[v].dig, vecs[v].dpv, vecs[v].blank, vecs[v].lz, vecs[v].br,
               lit_cnt[3], lit_cnt[2], lit_cnt[1], lit_cnt[0], n_fail - fails_before);
    end

    // Two loads mid-frame: nothing changes until the frame boundary, then the last one shows.
    brightness = 2'b11; lz_suppress = 1'b0;
    wait_tick("tear_align");
    repeat (10) step();
    do_load(16'hAAAA, 4'h0, 4'h0);
    repeat (5) step();
    do_load(16'hBBBB, 4'h0, 4'h0);
    n = 0; got = 0; early = 0;
    while (!got && n < 2 * FRAME) begin
      step();
      n++;
      if (an !== 4'hF && (seg === seg_of(4'hA) || seg === seg_of(4'hB))) early++;
      got = (frame_tick === 1'b1);
    end
    check_int("tear_tick_seen", int'(got), 1);
    check_int("tear_early_update", early, 0);
    check_frame_shows("tear_last_wins", 4'hB);
    $display("tear-free: early updates=%0d, frame after tick shows B", early);

    // Pending shadow D, then a load of C landing exactly in the wrap cycle.
    repeat (5) step();
    do_load(16'hDDDD, 4'h0, 4'h0);
    while ((m_cyc % FRAME) != FRAME - 1) step();
    digits_in = 16'hCCCC; load = 1'b1;
    step();
    load = 1'b0;
    check_int("wrap_load_tick", int'(frame_tick), 1);
    check_frame_shows("wrap_load_pre_edge", 4'hD);
    check_frame_shows("wrap_load_next_frame", 4'hC);
    $display("wrap-cycle load: first frame D, following frame C");

    // Reset in slot 5 of digit 2 with a load pending.
    while ((m_cyc % FRAME) != 10) step();
    do_load(16'h9999, 4'hF, 4'h0);
    while ((m_cyc % FRAME) != 2 * P + 5) step();
    reset = 1'b1;
    step();
    check_int("midreset_an", int'(an), 15);
    check_int("midreset_seg", int'(seg), 127);
    check_int("midreset_dp", int'(dp), 1);
    check_int("midreset_tick", int'(frame_tick), 0);
    reset = 1'b0;
    dark_frames("midreset_restart");

    // Random traffic against the reference model.
    fails_before = n_fail;
    for (int k = 0; k < 1500; k++) begin
      load = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        digits_in = 16'($urandom);
        if ($urandom_range(0, 1) == 1) digits_in[15:8] = 8'h00;
        dp_in     = 4'($urandom);
        blank_in  = 4'($urandom) & 4'($urandom);
        load      = 1'b1;
      end
      if ($urandom_range(0, 31) == 0) brightness = 2'($urandom);
      if ($urandom_range(0, 63) == 0) lz_suppress = 1'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    load = 1'b0; reset = 1'b0;
    $display("random: 1500 cycles, new_fails=%0d", n_fail - fails_before);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
